em_pick_drop_seq: RTL

- Command-side sequencer for the electromagnet driver. It generates the 1-bit PICK/DROP `state` line that the magnet driver consumes.
- Accepts pick/drop requests from the path/navigation FSM over a valid/ready handshake.
- Holds the magnet energised or released for a settle window, then confirms the result against the block-present sensor.
- Reports completion or failure back to the requester.

---
 rtl/em_pick_drop_seq_pkg.sv | 25 ++
 rtl/em_pick_drop_seq_sync.sv | 32 +++
 rtl/em_pick_drop_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/em_pick_drop_seq_pkg.sv
// -----------------------------------------------------------------------------
// em_pkg
//   Shared definitions for the electromagnet pick/drop sequencer.
//   - EM_PICK / EM_DROP : encoding of the magnet driver `state` line; the
//     driver uses the same values.
//   - OP_PICK / OP_DROP : encoding of the requester's cmd_op field.
//   - seq_state_e       : sequencer FSM states.
// -----------------------------------------------------------------------------
package em_pkg;

   localparam logic EM_PICK = 1'b0;  // magnet energised
   localparam logic EM_DROP = 1'b1;  // magnet off

   localparam logic OP_PICK = 1'b0;
   localparam logic OP_DROP = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENERGIZE = 3'd1,
      ST_CHK_PICK = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_CHK_DROP = 3'd4
   } seq_state_e;

endpackage

// File: rtl/em_pick_drop_seq_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level input.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset (output resets to 0)
//     d     in  asynchronous input
//     q     out synchronised copy of d, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/em_pick_drop_seq.sv
// -----------------------------------------------------------------------------
// em_pick_drop_seq
//   Command-side sequencer for the electromagnet driver. Accepts PICK/DROP
//   requests, holds the magnet energised (or released) for a settle window,
//   then confirms the outcome on the synchronised block-present sensor.
//   Ports:
//     clk       in  system clock
//     rst_n     in  asynchronous active-low reset
//     cmd_valid in  request present, held until accepted
//     cmd_ready out sequencer can accept (IDLE and out of reset)
//     cmd_op    in  0 = PICK, 1 = DROP, sampled on acceptance
//     sense     in  asynchronous block-present sensor
//     em_state  out magnet driver state: 0 = PICK (on), 1 = DROP (off)
//     done      out one-cycle success pulse
//     err       out one-cycle failure pulse
//     holding   out level: block confirmed on the magnet
//
//   Handshake: a request transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high; the requester keeps cmd_valid and cmd_op stable
//   until then, and cmd_ready never depends on cmd_valid.
// -----------------------------------------------------------------------------
module em_pick_drop_seq
   import em_pkg::*;
#(
   parameter int SETTLE_CYC  = 50000,
   parameter int RELEASE_CYC = 25000,
   parameter int RETRY_MAX   = 2,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cmd_valid,
   output logic cmd_ready,
   input  logic cmd_op,
   input  logic sense,
   output logic em_state,
   output logic done,
   output logic err,
   output logic holding
);

   localparam int RTR_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYC - 1);
   localparam logic [RTR_W-1:0] RETRY_LIMIT  = RTR_W'(RETRY_MAX);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RTR_W-1:0]  retry_q, retry_d;
   logic              em_state_q, em_state_d;
   logic              holding_q, holding_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   // Redundant PICK (already holding) acknowledges one edge after acceptance.
   logic              ack_q, ack_d;
   // Keeps cmd_ready low while reset is asserted and for the release edge.
   logic              run_q, run_d;
   logic              s_sync;

   sync_2ff u_sense_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sense),
      .q     (s_sync)
   );

   assign cmd_ready = run_q && (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      em_state_d = em_state_q;
      holding_d  = holding_q;
      done_d     = ack_q;
      err_d      = 1'b0;
      ack_d      = 1'b0;
      run_d      = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_op == OP_DROP) begin
                  em_state_d = EM_DROP;
                  cnt_d      = RELEASE_LOAD;
                  state_d    = ST_RELEASE;
               end else if (holding_q) begin
                  ack_d = 1'b1;
               end else begin
                  em_state_d = EM_PICK;
                  cnt_d      = SETTLE_LOAD;
                  retry_d    = '0;
                  state_d    = ST_ENERGIZE;
               end
            end
         end

         ST_ENERGIZE: begin
            if (cnt_q == '0) state_d = ST_CHK_PICK;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_CHK_PICK: begin
            if (s_sync) begin
               holding_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end else if (retry_q < RETRY_LIMIT) begin
               // Magnet stays on for another full settle window.
               retry_d = retry_q + 1'b1;
               cnt_d   = SETTLE_LOAD;
               state_d = ST_ENERGIZE;
            end else begin
               em_state_d = EM_DROP;
               holding_d  = 1'b0;
               err_d      = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         ST_RELEASE: begin
            if (cnt_q == '0) state_d = ST_CHK_DROP;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_CHK_DROP: begin
            holding_d = 1'b0;
            if (s_sync) err_d  = 1'b1;  // block stuck to the magnet
            else        done_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Async reset forces the magnet off the instant rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         retry_q    <= '0;
         em_state_q <= EM_DROP;
         holding_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_q      <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         em_state_q <= em_state_d;
         holding_q  <= holding_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
         run_q      <= run_d;
      end
   end

   assign em_state = em_state_q;
   assign done     = done_q;
   assign err      = err_q;
   assign holding  = holding_q;

endmodule
